alu_wide: RTL and testbench
===========================

ALU_WIDE -- requirements
Module: alu_wide

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 RDY  input  1  clock enable; when low all state SHALL hold.
REQ-005 start  input  1  request; sampled only when RDY=1 and busy=0.
REQ-006 op  input  4  0011 AI+BI, 0111 AI-BI, 1011 AI+AI, 1100 OR, 1101 AND, 1110 XOR, 1111 pass AI; other codes reserved.
REQ-007 right  input  1  rotate-right mode; overrides op.
REQ-008 BCD  input  1  decimal mode; applies to 0011/0111 only.
REQ-009 AI, BI  input  WIDTH  operands.
REQ-010 CI  input  1  carry in.
REQ-011 OUT  output  WIDTH  registered result.
REQ-012 CO, V, Z, N, HC  output  1 each  carry, overflow, zero, negative, half carry.
REQ-013 busy  output  1  decimal operation in progress.
REQ-014 done  output  1  one-cycle pulse: OUT and flags updated.

Function
REQ-015 Accept: rising edge with RDY=1, busy=0, start=1; AI, BI, op, right, BCD, CI latched at that edge.
REQ-016 Binary path (BCD=0, or op not 0011/0111): OUT/flags registered at the accept edge; done=1 for the following cycle; latency 1.
REQ-017 Decimal path: states IDLE -> RUN -> IDLE; one nibble per RDY-qualified edge, nibble 0 first; WIDTH/4 edges from accept to last nibble; busy=1 from the cycle after accept until the cycle after the last nibble; done pulses in the cycle after the last nibble.
REQ-018 Add: each nibble = a + b + c_in; if sum > 9 add 6, nibble carry = 1.
REQ-019 Subtract: each nibble = a + ~b + c_in (mod 16); if raw nibble carry = 0, subtract 6 (mod 16); nibble carry = raw carry.
REQ-020 Binary add/sub: OUT = AI + BI + CI, or AI + ~BI + CI; CO = carry out of bit WIDTH-1.
REQ-021 1011: OUT = {AI[WIDTH-2:0], CI}; CO = AI[WIDTH-1].
REQ-022 Logic ops and pass: CO=0, V=0, HC=0.
REQ-023 right=1: OUT = {CI, AI[WIDTH-1:1]}; CO = AI[0]; V=0; HC=0.
REQ-024 Reserved op codes: OUT=0, CO=0, V=0; done pulses normally.
REQ-025 N = OUT[WIDTH-1]; Z = (OUT == 0); both combinational from OUT.
REQ-026 V (add/sub) = operand MSBs (AI, effective BI) equal and uncorrected sum MSB differs from AI MSB.
REQ-027 HC = carry out of nibble 0, after decimal correction in BCD mode.
REQ-028 start while busy=1 SHALL be ignored; start in the done cycle is accepted.
REQ-029 OUT and flags hold until the next completed operation.
REQ-030 RDY=0 in RUN freezes the nibble counter and partial result; latency extends one cycle per stalled cycle.

Reset
REQ-031 reset_n=0 at a rising edge: OUT=0, CO=0, V=0, N=0, HC=0, Z=1, busy=0, done=0, state IDLE; reset takes priority over RDY.
REQ-032 Reset during RUN aborts the operation; the partial result is discarded and no done pulse is generated.

Configuration
REQ-033 Macro ALU_DECIMAL_EN defined: decimal path per REQ-017..REQ-019.
REQ-034 Macro ALU_DECIMAL_EN undefined: BCD ignored; every operation takes the binary path (latency 1); busy is constant 0.

Verification (WIDTH=16, ALU_DECIMAL_EN defined unless noted)
REQ-035 Add 0x7FFF+0x0001, CI=0, BCD=0 -> done in the next cycle; OUT=0x8000, N=1, V=1, CO=0, Z=0.
REQ-036 BCD add 0x0999+0x0001, CI=0 -> busy high 4 cycles; done pulse; OUT=0x1000, HC=1, CO=0.
REQ-037 BCD subtract 0x1000-0x0001, CI=1 -> OUT=0x0999, CO=1, Z=0, after 4 busy cycles.
REQ-038 right=1, AI=0x8001, CI=1 -> OUT=0xC000, CO=1, N=1; latency 1.
REQ-039 BCD add with RDY low 3 cycles mid-RUN and start pulsed while busy -> done delayed 3 cycles; OUT matches the unstalled result; the second start is ignored.
REQ-040 reset_n low during RUN -> next cycle busy=0, OUT=0, Z=1, no done pulse; with ALU_DECIMAL_EN undefined, BCD add 0x0009+0x0001 -> OUT=0x000A in 1 cycle.

Source files
------------

// File: rtl/alu_wide_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_wide_if -- request, operand and result bundle for alu_wide.  Rev 1.0
// ---------------------------------------------------------------------------
interface alu_wide_if #(
  parameter int WIDTH = 8
);
  logic             RDY;
  logic             start;
  logic [3:0]       op;
  logic             right;
  logic             BCD;
  logic [WIDTH-1:0] AI;
  logic [WIDTH-1:0] BI;
  logic             CI;
  logic [WIDTH-1:0] OUT;
  logic             CO;
  logic             V;
  logic             Z;
  logic             N;
  logic             HC;
  logic             busy;
  logic             done;

  modport master (
    output RDY, start, op, right, BCD, AI, BI, CI,
    input  OUT, CO, V, Z, N, HC, busy, done
  );

  modport slave (
    input  RDY, start, op, right, BCD, AI, BI, CI,
    output OUT, CO, V, Z, N, HC, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/alu_wide.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_wide -- WIDTH-bit ALU: 1-cycle binary path; nibble-serial BCD add/sub
// when macro ALU_DECIMAL_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
module alu_wide #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  alu_wide_if.slave bus
);
  localparam int NIBS = WIDTH / 4;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;

  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_DBL  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;

  logic [WIDTH-1:0] out_q;
  logic             co_q;
  logic             v_q;
  logic             hc_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_sum;
  logic [4:0]       add_lo;
  logic [WIDTH-1:0] bin_out;
  logic             bin_co;
  logic             bin_v;
  logic             bin_hc;

  // 1011 is AI+AI+CI, which is exactly the left shift with CI in and MSB out
  always_comb begin
    add_b = bus.BI;
    if (bus.op == OP_SUB)
      add_b = ~bus.BI;
    else if (bus.op == OP_DBL)
      add_b = bus.AI;
    add_sum = {1'b0, bus.AI} + {1'b0, add_b} + {{WIDTH{1'b0}}, bus.CI};
    add_lo  = {1'b0, bus.AI[3:0]} + {1'b0, add_b[3:0]} + {4'b0000, bus.CI};

    bin_out = '0;
    bin_co  = 1'b0;
    bin_v   = 1'b0;
    bin_hc  = 1'b0;
    if (bus.right) begin
      bin_out = {bus.CI, bus.AI[WIDTH-1:1]};
      bin_co  = bus.AI[0];
    end else begin
      case (bus.op)
        OP_ADD, OP_SUB, OP_DBL: begin
          bin_out = add_sum[WIDTH-1:0];
          bin_co  = add_sum[WIDTH];
          bin_v   = (bus.AI[WIDTH-1] == add_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != bus.AI[WIDTH-1]);
          bin_hc  = add_lo[4];
        end
        OP_OR:   bin_out = bus.AI | bus.BI;
        OP_AND:  bin_out = bus.AI & bus.BI;
        OP_XOR:  bin_out = bus.AI ^ bus.BI;
        OP_PASS: bin_out = bus.AI;
        default: bin_out = '0;
      endcase
    end
  end

`ifdef ALU_DECIMAL_EN
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_NIB = CW'(NIBS - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-5:0] res_q;
  logic             sub_q;
  logic             c_q;
  logic             hc_p;
  logic [CW-1:0]    nib_q;

  logic [4:0]       d_raw;
  logic [3:0]       d_nib;
  logic             d_carry;
  logic [WIDTH-1:0] res_next;
  logic             is_dec;

  assign is_dec = bus.BCD && !bus.right && ((bus.op == OP_ADD) || (bus.op == OP_SUB));

  // Operands shift right each step, so the active nibble is always [3:0]
  always_comb begin
    d_raw   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
    d_nib   = d_raw[3:0];
    d_carry = d_raw[4];
    if (sub_q) begin
      if (!d_raw[4])
        d_nib = d_raw[3:0] - 4'd6;
    end else if (d_raw > 5'd9) begin
      d_nib   = d_raw[3:0] + 4'd6;
      d_carry = 1'b1;
    end
    res_next = {d_nib, res_q};
  end
`else
  logic unused_bcd;
  assign unused_bcd = bus.BCD;
  assign busy_q     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q  <= '0;
      co_q   <= 1'b0;
      v_q    <= 1'b0;
      hc_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_DECIMAL_EN
      state  <= IDLE;
      busy_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      sub_q  <= 1'b0;
      c_q    <= 1'b0;
      hc_p   <= 1'b0;
      nib_q  <= '0;
`endif
    end else if (bus.RDY) begin
      done_q <= 1'b0;
`ifdef ALU_DECIMAL_EN
      if (state == RUN) begin
        a_q   <= a_q >> 4;
        b_q   <= b_q >> 4;
        c_q   <= d_carry;
        res_q <= res_next[WIDTH-1:4];
        nib_q <= nib_q + 1'b1;
        if (nib_q == '0)
          hc_p <= d_carry;
        if (nib_q == LAST_NIB) begin
          out_q  <= res_next;
          co_q   <= d_carry;
          v_q    <= (a_q[3] == b_q[3]) && (d_raw[3] != a_q[3]);
          hc_q   <= hc_p;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      end else if (bus.start && is_dec) begin
        a_q    <= bus.AI;
        b_q    <= add_b;
        sub_q  <= (bus.op == OP_SUB);
        c_q    <= bus.CI;
        res_q  <= '0;
        nib_q  <= '0;
        busy_q <= 1'b1;
        state  <= RUN;
      end else
`endif
      if (bus.start) begin
        out_q  <= bin_out;
        co_q   <= bin_co;
        v_q    <= bin_v;
        hc_q   <= bin_hc;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.OUT  = out_q;
  assign bus.CO   = co_q;
  assign bus.V    = v_q;
  assign bus.HC   = hc_q;
  assign bus.Z    = (out_q == '0);
  assign bus.N    = out_q[WIDTH-1];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_wide.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_wide -- directed vectors and done-driven scoreboard for alu_wide
// at WIDTH=16; expectations follow ALU_DECIMAL_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_wide;
  localparam int W = 16;
`ifdef ALU_DECIMAL_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  localparam int DLAT  = DEC ? 5 : 1;
  localparam int DBUSY = DEC ? 4 : 0;

  localparam logic [3:0] ADD  = 4'b0011;
  localparam logic [3:0] SUB  = 4'b0111;
  localparam logic [3:0] DBL  = 4'b1011;
  localparam logic [3:0] LOR  = 4'b1100;
  localparam logic [3:0] LAND = 4'b1101;
  localparam logic [3:0] LXOR = 4'b1110;
  localparam logic [3:0] PASS = 4'b1111;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   fails   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_wide_if #(.WIDTH(W)) bus ();
  alu_wide #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         co;
    logic         v;
    logic         hc;
    bit           chk_v;
    bit           chk_hc;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  function automatic void chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endfunction

  function automatic void chk16(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endfunction

  function automatic void chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void push_exp(input string nm, input logic [W-1:0] eo, input logic eco,
                                   input logic ev, input logic ehc, input bit cv, input bit chc,
                                   input int dcyc);
    exp_t e;
    e.name = nm; e.out = eo; e.co = eco; e.v = ev; e.hc = ehc;
    e.chk_v = cv; e.chk_hc = chc; e.cyc = dcyc;
    sb.push_back(e);
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        chk1("spurious_done", bus.done, 1'b0);
      end else begin
        e = sb.pop_front();
        chk16({e.name, "_out"}, bus.OUT, e.out);
        chk1({e.name, "_co"}, bus.CO, e.co);
        chk1({e.name, "_z"}, bus.Z, (e.out == '0));
        chk1({e.name, "_n"}, bus.N, e.out[W-1]);
        if (e.chk_v)  chk1({e.name, "_v"}, bus.V, e.v);
        if (e.chk_hc) chk1({e.name, "_hc"}, bus.HC, e.hc);
        chkn({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic rt, input logic bcd,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int lat,
                       input logic [W-1:0] eo, input logic eco, input logic ev, input logic ehc,
                       input bit cv, input bit chc, input bit push);
    @(negedge clk);
    bus.op = op; bus.right = rt; bus.BCD = bcd;
    bus.AI = a;  bus.BI = b;     bus.CI = ci;
    bus.start = 1'b1;
    if (push) push_exp(nm, eo, eco, ev, ehc, cv, chc, cyc + lat);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string nm);
    #1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chkn({"drain_", nm}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic count_busy(input string nm, input int expn);
    int n = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) break;
      if (bus.busy) n++;
      @(negedge clk);
      #1;
    end
    chkn({"busy_cycles_", nm}, n, expn);
    chk1({"busy_at_done_", nm}, bus.busy, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RDY = 1'b1; bus.start = 1'b0; bus.op = 4'b0000; bus.right = 1'b0;
    bus.BCD = 1'b0; bus.AI = '0;      bus.BI = '0;      bus.CI = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk16("rst_out", bus.OUT, 16'h0000);
    chk1("rst_z", bus.Z, 1'b1);
    chk1("rst_n", bus.N, 1'b0);
    chk1("rst_co", bus.CO, 1'b0);
    chk1("rst_v", bus.V, 1'b0);
    chk1("rst_hc", bus.HC, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    reset_n = 1'b1;

    // Binary path vectors: name, op, right, BCD, AI, BI, CI, latency, OUT, CO, V, HC
    issue("add_ovf",  ADD,  0, 0, 16'h7FFF, 16'h0001, 0, 1, 16'h8000, 0, 1, 1, 1, 1, 1); drain("add_ovf");
    issue("add_wrap", ADD,  0, 0, 16'hFFFF, 16'h0001, 0, 1, 16'h0000, 1, 0, 1, 1, 1, 1); drain("add_wrap");
    issue("sub_neg",  SUB,  0, 0, 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0, 1, 1, 1); drain("sub_neg");
    issue("sub_ovf",  SUB,  0, 0, 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1, 0, 1, 1, 1); drain("sub_ovf");
    issue("rotr",     ADD,  1, 1, 16'h8001, 16'hFFFF, 1, 1, 16'hC000, 1, 0, 0, 1, 1, 1); drain("rotr");
    issue("dbl",      DBL,  0, 0, 16'hC003, 16'h0000, 1, 1, 16'h8007, 1, 0, 0, 0, 0, 1); drain("dbl");
    issue("or",       LOR,  0, 0, 16'hF0F0, 16'h0FF0, 1, 1, 16'hFFF0, 0, 0, 0, 1, 1, 1); drain("or");
    issue("and",      LAND, 0, 0, 16'hF0F0, 16'h0F0F, 1, 1, 16'h0000, 0, 0, 0, 1, 1, 1); drain("and");
    issue("xor",      LXOR, 0, 0, 16'hAAAA, 16'h5555, 1, 1, 16'hFFFF, 0, 0, 0, 1, 1, 1); drain("xor");
    issue("pass",     PASS, 0, 0, 16'h1234, 16'hFFFF, 1, 1, 16'h1234, 0, 0, 0, 1, 1, 1); drain("pass");
    issue("rsvd0",    4'b0000, 0, 0, 16'hFFFF, 16'hFFFF, 1, 1, 16'h0000, 0, 0, 0, 1, 0, 1); drain("rsvd0");
    issue("rsvd8",    4'b1000, 0, 0, 16'h1234, 16'h4321, 1, 1, 16'h0000, 0, 0, 0, 1, 0, 1); drain("rsvd8");
    issue("bcd_or",   LOR,  0, 1, 16'h0F00, 16'h00F0, 0, 1, 16'h0FF0, 0, 0, 0, 1, 1, 1); drain("bcd_or");

    // Decimal-mode vectors (binary results when the decimal path is absent)
    issue("bcd_add", ADD, 0, 1, 16'h0999, 16'h0001, 0, DLAT,
          DEC ? 16'h1000 : 16'h099A, 0, 0, DEC, 0, 1, 1);
    count_busy("bcd_add", DBUSY); drain("bcd_add");
    issue("bcd_sub", SUB, 0, 1, 16'h1000, 16'h0001, 1, DLAT,
          DEC ? 16'h0999 : 16'h0FFF, 1, 0, 0, 0, 1, 1);
    count_busy("bcd_sub", DBUSY); drain("bcd_sub");
    issue("bcd_addc", ADD, 0, 1, 16'h4567, 16'h1234, 1, DLAT,
          DEC ? 16'h5802 : 16'h579C, 0, 0, DEC, 0, 1, 1); drain("bcd_addc");
    issue("bcd_wrap", ADD, 0, 1, 16'h9999, 16'h0001, 0, DLAT,
          DEC ? 16'h0000 : 16'h999A, DEC, 0, DEC, 0, 1, 1); drain("bcd_wrap");
    issue("bcd_9p1", ADD, 0, 1, 16'h0009, 16'h0001, 0, DLAT,
          DEC ? 16'h0010 : 16'h000A, 0, 0, DEC, 0, 1, 1); drain("bcd_9p1");

    // A start presented in the done cycle must be accepted
    issue("dc_first", ADD, 0, 1, 16'h0001, 16'h0001, 0, DLAT, 16'h0002, 0, 0, 0, 0, 1, 1);
    #1;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(negedge clk);
      #1;
    end
    chk1("dc_done_seen", bus.done, 1'b1);
    bus.op = PASS; bus.right = 1'b0; bus.BCD = 1'b0; bus.AI = 16'h5A5A; bus.start = 1'b1;
    push_exp("dc_second", 16'h5A5A, 0, 0, 0, 1, 1, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    drain("dc");

    // RDY low holds everything, including a pending start
    @(negedge clk);
    bus.RDY = 1'b0; bus.op = PASS; bus.AI = 16'h1357; bus.CI = 1'b0; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk16("hold_out", bus.OUT, 16'h5A5A);
    chk1("hold_done", bus.done, 1'b0);
    bus.RDY = 1'b1;
    push_exp("rdy_gate", 16'h1357, 0, 0, 0, 1, 1, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    drain("rdy_gate");

`ifdef ALU_DECIMAL_EN
    // Stall mid-RUN for 3 cycles, then a start while busy that must be ignored
    issue("stall", ADD, 0, 1, 16'h0999, 16'h0001, 0, DLAT + 3, 16'h1000, 0, 0, 1, 0, 1, 1);
    @(negedge clk);
    bus.RDY = 1'b0;
    repeat (3) @(negedge clk);
    bus.RDY = 1'b1; bus.op = PASS; bus.BCD = 1'b0; bus.AI = 16'h5555; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain("stall");
    repeat (4) @(negedge clk);
    chk16("stall_hold_out", bus.OUT, 16'h1000);
`endif

    // Reset while a decimal operation is running aborts it without done
    issue("abort", ADD, 0, 1, 16'h0999, 16'h0001, 0, 1, 16'h099A, 0, 0, 0, 1, 1, !DEC);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk1("abort_busy", bus.busy, 1'b0);
    chk16("abort_out", bus.OUT, 16'h0000);
    chk1("abort_z", bus.Z, 1'b1);
    chk1("abort_done", bus.done, 1'b0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk1("abort_idle_busy", bus.busy, 1'b0);

    drain("final");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
